rede_collect: RTL and testbench
===============================

Name: rede_collect

Overview:
- Downstream collector for the 24-core rede_float array.
- Captures every core's result pulse into a one-deep holding slot per core, so simultaneous results are not lost.
- A round-robin arbiter moves held results into a shared FIFO.
- The FIFO presents {core index, result} on a valid/ready stream to the host-side consumer.

Parameters:
- NCORES, 24: number of cores observed.
- DATA_W, 28: result width, signed.
- EN_W, 4: width of each core's out_en code.
- FIFO_DEPTH, 16: shared FIFO entries; must be a power of 2, at least 2.
- IDX_W, 5: core index width, ceil(log2(NCORES)).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- io_out_bus  in  NCORES*DATA_W  core results; core k occupies bits [k*DATA_W +: DATA_W].
- out_en_bus  in  NCORES*EN_W  core out_en codes; core k occupies bits [k*EN_W +: EN_W].
- m_valid  out  1  stream word available.
- m_ready  in  1  consumer accepts the word.
- m_idx  out  IDX_W  source core index of the current word.
- m_data  out  DATA_W  signed result of the current word.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  NCORES  sticky per-core overrun flags.
- ovr_clr  in  1  single-cycle pulse; clears all overrun flags.

Behaviour:
- Reset (rst=0, asynchronous), all of the following are 0:
  - m_valid, m_idx, m_data, fifo_level, overrun;
  - all holding-slot valid bits;
  - the arbiter pointer.
- Result pulse: core k presents a result when its out_en field equals EN_VALID (4'd1). Any other code is ignored.
- Capture, cycle N:
  - A pulse on core k with slot k empty loads slot k at the edge ending cycle N.
  - Slot k is valid in cycle N+1.
- Arbiter:
  - Grants at most one valid slot per cycle.
  - Round-robin search begins at (last_grant+1) mod NCORES and wraps at NCORES-1 -> 0.
  - After reset the search starts at core 0.
  - A grant occurs only if the FIFO is not full, or is full and is being popped in the same cycle (m_valid & m_ready).
  - A grant writes {k, data} into the FIFO and clears slot k.
- Latency: pulse in cycle N, empty FIFO, no contention -> m_valid=1 in cycle N+2.
- Simultaneous events on the same slot:
  - If slot k is granted and a new pulse arrives on core k in the same cycle, the new value loads the slot. No overrun.
  - If slot k is full, not granted, and a new pulse arrives, the new value is dropped, the old value is kept, and overrun[k] is set.
- Overrun flags:
  - A flag set and ovr_clr in the same cycle leaves the flag set.
  - Otherwise ovr_clr clears all flags.
- Stream handshake:
  - m_idx and m_data are held stable while m_valid=1 and m_ready=0.
  - The word is popped on the edge where m_valid & m_ready.
  - FIFO empty -> m_valid=0; m_idx and m_data hold their last values.
- FIFO:
  - First-in first-out; pointers wrap mod FIFO_DEPTH.
  - fifo_level counts 0..FIFO_DEPTH.
  - Push and pop in the same cycle when full is legal; the level is unchanged.
- Mid-operation reset: all held and queued results are discarded. The cores are reset independently; there is no ordering requirement.

Optional Feature:
- Macro: REDE_COLLECT_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter, reset to 0 and wrapping at 16'hFFFF -> 0, is sampled into slot k on capture.
  - The sample travels through the FIFO and appears on an extra output port m_ts [15:0], aligned with m_data.
  - m_ts resets to 0.
- Undefined: no counter, no m_ts port, and FIFO width is IDX_W+DATA_W.

Decomposition:
- Package rede_collect_pkg holds:
  - DATA_W, EN_W, and EN_VALID=4'd1;
  - the default NCORES;
  - the FIFO entry typedef {idx, data[, ts]}.
- Sub-module rede_collect_fifo: synchronous FIFO, parameterised depth and width, with level output and full/empty.
- Capture slots, arbiter and overrun logic stay in the top module.

Test Plan:
- Single result: after reset, core 5 pulses out_en=1 with data=-1234 in cycle 10 -> m_valid rises in cycle 12 with m_idx=5 and m_data=-1234; with m_ready=1 the word pops and m_valid falls in cycle 13.
- Simultaneous burst: cores 0, 7 and 23 pulse in the same cycle; m_ready=1 -> three words in order idx 0, 7, 23 on consecutive cycles; overrun=0.
- Round-robin wrap: after a grant to core 22, cores 3 and 23 pulse together -> output order 23, then 3.
- Back-pressure/full: m_ready=0 while 20 distinct cores pulse -> fifo_level saturates at 16, 4 slots stay held and none are lost; raising m_ready drains exactly 20 words.
- Overrun: m_ready=0 with the FIFO full; core 2 pulses data=100, then data=200 -> overrun[2]=1 and only 100 is delivered; ovr_clr returns overrun to 0.
- Reset mid-stream: with fifo_level=6, assert rst=0 asynchronously between edges -> m_valid, fifo_level and overrun are 0 immediately, and no stale word appears after release.

Source files
------------

// File: rtl/rede_collect_pkg.sv
// Shared constants and the FIFO entry type for the rede_float result collector.
// Optional macro REDE_COLLECT_TIMESTAMP_EN adds a 16-bit capture timestamp to each entry.
package rede_collect_pkg;

   localparam int NCORES_DEF = 24;
   localparam int DATA_W     = 28;
   localparam int EN_W       = 4;
   localparam int IDX_W      = 5;
   localparam int TS_W       = 16;

   localparam logic [EN_W-1:0] EN_VALID = 4'd1;

   // One queued result: which core produced it and the signed value
   typedef struct packed {
      logic [IDX_W-1:0]         idx;
      logic signed [DATA_W-1:0] data;
`ifdef REDE_COLLECT_TIMESTAMP_EN
      logic [TS_W-1:0]          ts;
`endif
   } collectEntry_t;

endpackage

// File: rtl/rede_collect_fifo.sv
// Synchronous FIFO with a registered head word, occupancy level and full/empty flags.
// The head register keeps its last value when the FIFO drains, so the stream
// outputs hold steady while nothing is available.
module rede_collect_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 33,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      level_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pushEn, popEn;
   logic [AW-1:0]    headAddr;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = head_q;

   // Pointer, count and next-head computation; a push into the slot that becomes
   // the head is forwarded directly so the head register never sees stale memory
   always_comb begin
      popEn    = pop_i && !empty_o;
      pushEn   = push_i && (!full_o || popEn);
      rdPtr_d  = rdPtr_q + AW'(popEn);
      wrPtr_d  = wrPtr_q + AW'(pushEn);
      count_d  = count_q + (AW+1)'(pushEn) - (AW+1)'(popEn);
      headAddr = rdPtr_d;
      head_d   = head_q;
      if (count_d != '0) begin
         if (pushEn && (headAddr == wrPtr_q)) begin
            head_d = wdata_i;
         end else begin
            head_d = mem_q[headAddr];
         end
      end
   end

   // Storage array; contents are only meaningful between the pointers, so no reset
   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

   // Pointer, occupancy and head registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         head_q  <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

endmodule

// File: rtl/rede_collect.sv
// Result collector for the rede_float core array: one holding slot per core,
// a round-robin arbiter into a shared FIFO, and a valid/ready output stream.
// Optional macro REDE_COLLECT_TIMESTAMP_EN adds a cycle-counter sample on m_ts.
module rede_collect
   import rede_collect_pkg::*;
#(
   parameter  int NCORES     = NCORES_DEF,
   parameter  int FIFO_DEPTH = 16,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCORES*DATA_W-1:0] io_out_bus,
   input  logic [NCORES*EN_W-1:0]   out_en_bus,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [IDX_W-1:0]         m_idx,
   output logic signed [DATA_W-1:0] m_data,
   output logic [LVL_W-1:0]         fifo_level,
   output logic [NCORES-1:0]        overrun,
   input  logic                     ovr_clr
`ifdef REDE_COLLECT_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]          m_ts
`endif
);

   localparam int ENTRY_W = $bits(collectEntry_t);

   logic [NCORES-1:0]        slotValid_q, slotValid_d;
   logic signed [DATA_W-1:0] slotData_q [NCORES];
   logic signed [DATA_W-1:0] slotData_d [NCORES];
   logic [NCORES-1:0]        overrun_q, overrun_d;
   logic [NCORES-1:0]        ovrSet;
   logic [IDX_W-1:0]         ptr_q, ptr_d;
   logic [NCORES-1:0]        pulse;
   logic                     grantFound, grant;
   logic [IDX_W-1:0]         grantIdx;
   logic [NCORES-1:0]        grantMask;
   logic                     popFire, fifoFull, fifoEmpty;
   collectEntry_t            pushEntry, headEntry;
   logic [ENTRY_W-1:0]       fifoRdata;
   int                       cand;

`ifdef REDE_COLLECT_TIMESTAMP_EN
   logic [TS_W-1:0]          tsCount_q;
   logic [TS_W-1:0]          slotTs_q [NCORES];
   logic [TS_W-1:0]          slotTs_d [NCORES];
`endif

   assign popFire   = m_valid && m_ready;
   assign m_valid   = !fifoEmpty;
   assign headEntry = collectEntry_t'(fifoRdata);
   assign m_idx     = headEntry.idx;
   assign m_data    = headEntry.data;
   assign overrun   = overrun_q;
`ifdef REDE_COLLECT_TIMESTAMP_EN
   assign m_ts      = headEntry.ts;
`endif

   // Decode each core's out_en field into a one-bit result pulse
   always_comb begin
      pulse = '0;
      for (int k = 0; k < NCORES; k++) begin
         pulse[k] = (out_en_bus[k*EN_W +: EN_W] == EN_VALID);
      end
   end

   // Round-robin search starting at the pointer; a grant needs room in the FIFO,
   // which includes the case of a full FIFO being popped this cycle
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = 0;
      for (int i = 0; i < NCORES; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NCORES) begin
            cand = cand - NCORES;
         end
         if (!grantFound && slotValid_q[cand]) begin
            grantFound = 1'b1;
            grantIdx   = IDX_W'(cand);
         end
      end
      grant     = grantFound && (!fifoFull || popFire);
      grantMask = grant ? (NCORES'(1) << grantIdx) : '0;
      if (!grant) begin
         ptr_d = ptr_q;
      end else if (int'(grantIdx) == NCORES - 1) begin
         ptr_d = '0;
      end else begin
         ptr_d = grantIdx + IDX_W'(1);
      end
   end

   // Build the FIFO entry from the granted slot
   always_comb begin
      pushEntry      = '0;
      pushEntry.idx  = grantIdx;
      pushEntry.data = slotData_q[grantIdx];
`ifdef REDE_COLLECT_TIMESTAMP_EN
      pushEntry.ts   = slotTs_q[grantIdx];
`endif
   end

   // Slot next-state: a pulse loads an empty or just-granted slot, otherwise it
   // is dropped and flagged; the set side of overrun wins over a clear
   always_comb begin
      slotValid_d = slotValid_q;
      slotData_d  = slotData_q;
      ovrSet      = '0;
`ifdef REDE_COLLECT_TIMESTAMP_EN
      slotTs_d    = slotTs_q;
`endif
      for (int k = 0; k < NCORES; k++) begin
         if (pulse[k] && (!slotValid_q[k] || grantMask[k])) begin
            slotValid_d[k] = 1'b1;
            slotData_d[k]  = io_out_bus[k*DATA_W +: DATA_W];
`ifdef REDE_COLLECT_TIMESTAMP_EN
            slotTs_d[k]    = tsCount_q;
`endif
         end else if (grantMask[k]) begin
            slotValid_d[k] = 1'b0;
         end
         if (pulse[k] && slotValid_q[k] && !grantMask[k]) begin
            ovrSet[k] = 1'b1;
         end
      end
      overrun_d = (ovr_clr ? '0 : overrun_q) | ovrSet;
   end

   // Slot, overrun and arbiter pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slotValid_q <= '0;
         slotData_q  <= '{default: '0};
         overrun_q   <= '0;
         ptr_q       <= '0;
      end else begin
         slotValid_q <= slotValid_d;
         slotData_q  <= slotData_d;
         overrun_q   <= overrun_d;
         ptr_q       <= ptr_d;
      end
   end

`ifdef REDE_COLLECT_TIMESTAMP_EN
   // Free-running capture timestamp and the per-slot samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tsCount_q <= '0;
         slotTs_q  <= '{default: '0};
      end else begin
         tsCount_q <= tsCount_q + TS_W'(1);
         slotTs_q  <= slotTs_d;
      end
   end
`endif

   rede_collect_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (grant),
      .wdata_i (pushEntry),
      .pop_i   (popFire),
      .rdata_o (fifoRdata),
      .level_o (fifo_level),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

endmodule

// File: tb/tb_rede_collect.sv
// Self-checking bench for rede_collect: table of single-result vectors plus
// hand-written burst, wrap, back-pressure, overrun and mid-stream reset sequences.
// A scoreboard queue holds expected words; a negedge monitor checks each pop.
module tb_rede_collect;
   import rede_collect_pkg::*;

   localparam int NC    = 24;
   localparam int DEPTH = 16;

   logic                     clk;
   logic                     rst;
   logic [NC*DATA_W-1:0]     ioBus;
   logic [NC*EN_W-1:0]       enBus;
   logic                     mValid;
   logic                     mReady;
   logic [IDX_W-1:0]         mIdx;
   logic signed [DATA_W-1:0] mData;
   logic [$clog2(DEPTH):0]   fifoLevel;
   logic [NC-1:0]            overrun;
   logic                     ovrClr;
`ifdef REDE_COLLECT_TIMESTAMP_EN
   logic [15:0]              mTs;
`endif

   typedef struct {
      int                       idx;
      logic signed [DATA_W-1:0] data;
   } word_t;

   typedef struct {
      int                       core;
      logic [EN_W-1:0]          en;
      logic signed [DATA_W-1:0] data;
      bit                       expValid;
   } vec_t;

   word_t expQ[$];
   vec_t  vecs[7];
   int    checks = 0;
   int    errors = 0;
   int    popCount = 0;
   int    pc0;

   rede_collect #(
      .NCORES     (NC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_out_bus (ioBus),
      .out_en_bus (enBus),
      .m_valid    (mValid),
      .m_ready    (mReady),
      .m_idx      (mIdx),
      .m_data     (mData),
      .fifo_level (fifoLevel),
      .overrun    (overrun),
      .ovr_clr    (ovrClr)
`ifdef REDE_COLLECT_TIMESTAMP_EN
      ,
      .m_ts       (mTs)
`endif
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and record the result
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one core's result and out_en code
   task automatic applyStimulus(input int core, input logic [EN_W-1:0] en, input logic signed [DATA_W-1:0] data);
      ioBus[core*DATA_W +: DATA_W] = data;
      enBus[core*EN_W +: EN_W]     = en;
   endtask

   // Record an expected output word
   task automatic expectWord(input int idx, input logic signed [DATA_W-1:0] data);
      word_t w;
      w.idx  = idx;
      w.data = data;
      expQ.push_back(w);
   endtask

   // Advance n clocks and settle 1 ns past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset pulse that also discards pending expectations
   task automatic doReset();
      rst = 1'b0;
      expQ.delete();
      enBus  = '0;
      ovrClr = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
   endtask

   // Scoreboard monitor: every handshake must match the next expected word
   always @(negedge clk) begin
      if (rst && mValid && mReady) begin
         popCount++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stray_word: got idx %0d data %0d, expected no word", mIdx, mData);
         end else begin
            word_t e;
            e = expQ.pop_front();
            checkOutput("stream_idx", 64'(mIdx), 64'(e.idx));
            checkOutput("stream_data", 64'(mData), 64'(e.data));
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] timeout");
   end

   // Main test sequence
   initial begin
      vecs[0] = '{5,  4'd1, -28'sd1234,      1'b1};
      vecs[1] = '{0,  4'd1, 28'sd1,          1'b1};
      vecs[2] = '{23, 4'd1, 28'sd134217727,  1'b1};
      vecs[3] = '{12, 4'd1, -28'sd134217728, 1'b1};
      vecs[4] = '{9,  4'd2, 28'sd77,         1'b0};
      vecs[5] = '{4,  4'hF, 28'sd88,         1'b0};
      vecs[6] = '{17, 4'd1, 28'sd0,          1'b1};

      rst    = 1'b0;
      mReady = 1'b0;
      ovrClr = 1'b0;
      ioBus  = '0;
      enBus  = '0;
      #2;
      checkOutput("reset_valid", 64'(mValid), 64'(0));
      checkOutput("reset_idx", 64'(mIdx), 64'(0));
      checkOutput("reset_data", 64'(mData), 64'(0));
      checkOutput("reset_level", 64'(fifoLevel), 64'(0));
      checkOutput("reset_overrun", 64'(overrun), 64'(0));
      step(2);
      rst = 1'b1;
      step(2);

      // Single results: latency of two cycles, pop, then outputs hold
      mReady = 1'b1;
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].core, vecs[v].en, vecs[v].data);
         if (vecs[v].expValid) expectWord(vecs[v].core, vecs[v].data);
         step(1);
         enBus = '0;
         checkOutput("vec_valid_n1", 64'(mValid), 64'(0));
         step(1);
         checkOutput("vec_valid_n2", 64'(mValid), 64'(vecs[v].expValid));
         if (vecs[v].expValid) begin
            checkOutput("vec_idx_n2", 64'(mIdx), 64'(vecs[v].core));
            checkOutput("vec_data_n2", 64'(mData), 64'(vecs[v].data));
         end
         step(1);
         checkOutput("vec_valid_n3", 64'(mValid), 64'(0));
         if (vecs[v].expValid) begin
            checkOutput("vec_idx_hold", 64'(mIdx), 64'(vecs[v].core));
            checkOutput("vec_data_hold", 64'(mData), 64'(vecs[v].data));
         end
         step(2);
      end

      // Simultaneous burst from cores 0, 7, 23
      doReset();
      mReady = 1'b1;
      applyStimulus(0, 4'd1, 28'sd10);
      applyStimulus(7, 4'd1, 28'sd70);
      applyStimulus(23, 4'd1, -28'sd230);
      expectWord(0, 28'sd10);
      expectWord(7, 28'sd70);
      expectWord(23, -28'sd230);
      step(1);
      enBus = '0;
      step(1);
      checkOutput("burst_idx0", 64'(mIdx), 64'(0));
      step(1);
      checkOutput("burst_idx1", 64'(mIdx), 64'(7));
      step(1);
      checkOutput("burst_idx2", 64'(mIdx), 64'(23));
      step(1);
      checkOutput("burst_valid_end", 64'(mValid), 64'(0));
      checkOutput("burst_overrun", 64'(overrun), 64'(0));

      // Round-robin wrap: after core 22, core 23 beats core 3
      applyStimulus(22, 4'd1, -28'sd5);
      expectWord(22, -28'sd5);
      step(1);
      enBus = '0;
      step(4);
      applyStimulus(3, 4'd1, 28'sd33);
      applyStimulus(23, 4'd1, -28'sd23);
      expectWord(23, -28'sd23);
      expectWord(3, 28'sd33);
      step(1);
      enBus = '0;
      step(1);
      checkOutput("wrap_first", 64'(mIdx), 64'(23));
      step(1);
      checkOutput("wrap_second", 64'(mIdx), 64'(3));
      step(2);

      // Pulse on a slot in the same cycle it is granted: reloads, no overrun
      applyStimulus(6, 4'd1, 28'sd11);
      expectWord(6, 28'sd11);
      step(1);
      applyStimulus(6, 4'd1, 28'sd22);
      expectWord(6, 28'sd22);
      step(1);
      enBus = '0;
      step(4);
      checkOutput("regrant_overrun", 64'(overrun), 64'(0));
      checkOutput("regrant_drained", 64'(expQ.size()), 64'(0));

      // Back-pressure: 20 cores, FIFO saturates, 4 stay held
      doReset();
      mReady = 1'b0;
      for (int k = 0; k < 20; k++) begin
         logic signed [DATA_W-1:0] d;
         d = (k % 2 == 1) ? DATA_W'(-(k * 1000)) : DATA_W'(k * 1000 + 1);
         applyStimulus(k, 4'd1, d);
         expectWord(k, d);
      end
      step(1);
      enBus = '0;
      step(24);
      checkOutput("bp_level_full", 64'(fifoLevel), 64'(16));
      checkOutput("bp_valid", 64'(mValid), 64'(1));
      checkOutput("bp_head_idx", 64'(mIdx), 64'(0));
      checkOutput("bp_head_data", 64'(mData), 64'(1));
      step(3);
      checkOutput("bp_hold_idx", 64'(mIdx), 64'(0));
      pc0 = popCount;
      mReady = 1'b1;
      step(40);
      checkOutput("bp_drain_count", 64'(popCount - pc0), 64'(20));
      checkOutput("bp_queue_empty", 64'(expQ.size()), 64'(0));
      checkOutput("bp_level_empty", 64'(fifoLevel), 64'(0));
      checkOutput("bp_valid_end", 64'(mValid), 64'(0));
      checkOutput("bp_overrun", 64'(overrun), 64'(0));

      // Overrun: full FIFO, core 2 pulses twice; first value survives
      doReset();
      mReady = 1'b0;
      for (int k = 4; k < 20; k++) begin
         applyStimulus(k, 4'd1, DATA_W'(k * 3));
         expectWord(k, DATA_W'(k * 3));
      end
      step(1);
      enBus = '0;
      step(20);
      checkOutput("ovr_level_full", 64'(fifoLevel), 64'(16));
      applyStimulus(2, 4'd1, 28'sd100);
      expectWord(2, 28'sd100);
      step(1);
      enBus = '0;
      step(1);
      checkOutput("ovr_not_yet", 64'(overrun), 64'(0));
      applyStimulus(2, 4'd1, 28'sd200);
      step(1);
      enBus = '0;
      checkOutput("ovr_set", 64'(overrun), 64'(24'h000004));
      applyStimulus(2, 4'd1, 28'sd300);
      ovrClr = 1'b1;
      step(1);
      enBus  = '0;
      ovrClr = 1'b0;
      checkOutput("ovr_set_beats_clr", 64'(overrun), 64'(24'h000004));
      ovrClr = 1'b1;
      step(1);
      ovrClr = 1'b0;
      checkOutput("ovr_cleared", 64'(overrun), 64'(0));
      pc0 = popCount;
      mReady = 1'b1;
      step(30);
      checkOutput("ovr_drain_count", 64'(popCount - pc0), 64'(17));
      checkOutput("ovr_queue_empty", 64'(expQ.size()), 64'(0));

      // Asynchronous reset mid-stream discards everything
      doReset();
      mReady = 1'b0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(k, 4'd1, DATA_W'(k + 40));
      end
      step(1);
      enBus = '0;
      step(8);
      checkOutput("mid_level_six", 64'(fifoLevel), 64'(6));
      @(posedge clk);
      #3;
      rst = 1'b0;
      expQ.delete();
      #1;
      checkOutput("mid_valid", 64'(mValid), 64'(0));
      checkOutput("mid_level", 64'(fifoLevel), 64'(0));
      checkOutput("mid_overrun", 64'(overrun), 64'(0));
      checkOutput("mid_idx", 64'(mIdx), 64'(0));
      step(1);
      rst = 1'b1;
      mReady = 1'b1;
      step(10);
      checkOutput("mid_no_stale", 64'(mValid), 64'(0));
      checkOutput("mid_level_after", 64'(fifoLevel), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
